serial_operand_loader: RTL

- Upstream feeder for the serial comparator datapath.
- Accepts two WIDTH-bit operands in parallel through a valid/ready load handshake.
- Shifts the operands out one bit pair per transfer, with first/last framing, to the bit-serial comparator stage.
- Supports downstream backpressure. The comparator's per-bit state flop uses bit_first to clear and bit_last to finalise.

---
 rtl/serial_operand_loader.sv | 100 ++++++++++
 1 files changed

// File: rtl/serial_operand_loader.sv
// Upstream feeder for the bit-serial comparator: loads two operands in parallel
// and streams them out one bit pair per transfer with first/last framing.
module serial_operand_loader #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             a_bit,
  output logic             b_bit,
  output logic             bit_valid,
  input  logic             bit_ready,
  output logic             bit_first,
  output logic             bit_last,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] sra;
  logic [WIDTH-1:0] srb;
  logic [WIDTH-1:0] sra_next;
  logic [WIDTH-1:0] srb_next;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_next;
  logic             last_pair;

  assign last_pair = (count == LAST_COUNT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      sra   <= '0;
      srb   <= '0;
      count <= '0;
    end else begin
      state <= state_next;
      sra   <= sra_next;
      srb   <= srb_next;
      count <= count_next;
    end
  end

  // Registers hold by default, which is what gives the stall behaviour.
  always_comb begin
    state_next = state;
    sra_next   = sra;
    srb_next   = srb;
    count_next = count;
    case (state)
      IDLE: begin
        if (load_valid) begin
          sra_next   = a_in;
          srb_next   = b_in;
          count_next = '0;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_ready) begin
          if (last_pair) begin
            sra_next   = '0;
            srb_next   = '0;
            count_next = '0;
            state_next = IDLE;
          end else begin
            sra_next   = MSB_FIRST ? (sra << 1) : (sra >> 1);
            srb_next   = MSB_FIRST ? (srb << 1) : (srb >> 1);
            count_next = count + 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Outputs decode registered state only, so reset drops them without a clock.
  assign load_ready = (state == IDLE);
  assign bit_valid  = (state == SHIFT);
  assign busy       = (state == SHIFT);
  assign a_bit      = bit_valid & (MSB_FIRST ? sra[WIDTH-1] : sra[0]);
  assign b_bit      = bit_valid & (MSB_FIRST ? srb[WIDTH-1] : srb[0]);
  assign bit_first  = bit_valid & (count == '0);
  assign bit_last   = bit_valid & last_pair;

endmodule
